// File: rtl/jtag_tck_shifter_if.sv
// Command/response channel between the tx/rx memory logic and the JTAG bit shifter.
// The master issues shift commands and drains captured TDO words.
interface jtag_tck_shifter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 6
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [DATA_WIDTH-1:0] cmd_tms;
   logic [DATA_WIDTH-1:0] cmd_tdi;
   logic [LEN_WIDTH-1:0]  cmd_len;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_tdo;

   modport master (
      output cmd_valid,
      output cmd_tms,
      output cmd_tdi,
      output cmd_len,
      output rsp_ready,
      input  cmd_ready,
      input  rsp_valid,
      input  rsp_tdo
   );

   modport slave (
      input  cmd_valid,
      input  cmd_tms,
      input  cmd_tdi,
      input  cmd_len,
      input  rsp_ready,
      output cmd_ready,
      output rsp_valid,
      output rsp_tdo
   );
endinterface

// File: rtl/jtag_tck_shifter.sv
// Command-driven JTAG shifter: drives TCK/TMS/TDI for up to DATA_WIDTH bits per command
// and returns the TDO bit captured just before each TCK falling edge.
module jtag_tck_shifter #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 6,
   parameter int HP_WIDTH   = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   jtag_tck_shifter_if.slave   bus,
   input  logic [HP_WIDTH-1:0] half_period,
   output logic                tck,
   output logic                tms,
   output logic                tdi,
   input  logic                tdo,
   output logic                busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOW  = 2'd1;
   localparam logic [1:0] HIGH = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   logic [1:0]            state;
   logic [DATA_WIDTH-1:0] tms_pend;
   logic [DATA_WIDTH-1:0] tdi_pend;
   logic [DATA_WIDTH-1:0] bit_mask;
   logic [DATA_WIDTH-1:0] tdo_cap;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  bit_idx;
   logic [HP_WIDTH-1:0]   hp_q;
   logic [HP_WIDTH-1:0]   hp_cnt;
   logic                  tdo_meta;
   logic                  tdo_sync;
   logic [LEN_WIDTH-1:0]  len_eff;
   logic [HP_WIDTH-1:0]   hp_eff;
   logic                  hp_done;
   logic                  last_bit;

   // Over-long commands clamp to the word width; half-periods below 2 are too short to sample TDO.
   always_comb begin
      len_eff = bus.cmd_len;
      if (bus.cmd_len > LEN_WIDTH'(DATA_WIDTH))
         len_eff = LEN_WIDTH'(DATA_WIDTH);
      hp_eff = half_period;
      if (half_period < HP_WIDTH'(2))
         hp_eff = HP_WIDTH'(2);
   end

   assign hp_done       = (hp_cnt == hp_q - HP_WIDTH'(1));
   assign last_bit      = (bit_idx == len_q - LEN_WIDTH'(1));
   assign bus.cmd_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_tdo   = tdo_cap;
   assign busy          = (state != IDLE);

   // TDO comes from the target's TCK domain, so it is treated as fully asynchronous.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tdo_meta <= 1'b0;
         tdo_sync <= 1'b0;
      end else begin
         tdo_meta <= tdo;
         tdo_sync <= tdo_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         tck      <= 1'b0;
         tms      <= 1'b0;
         tdi      <= 1'b0;
         tms_pend <= '0;
         tdi_pend <= '0;
         bit_mask <= '0;
         tdo_cap  <= '0;
         len_q    <= '0;
         bit_idx  <= '0;
         hp_q     <= HP_WIDTH'(2);
         hp_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  len_q    <= len_eff;
                  hp_q     <= hp_eff;
                  hp_cnt   <= '0;
                  bit_idx  <= '0;
                  bit_mask <= DATA_WIDTH'(1);
                  tdo_cap  <= '0;
                  tms_pend <= bus.cmd_tms >> 1;
                  tdi_pend <= bus.cmd_tdi >> 1;
                  if (len_eff == '0) begin
                     state <= RESP;
                  end else begin
                     tms   <= bus.cmd_tms[0];
                     tdi   <= bus.cmd_tdi[0];
                     state <= LOW;
                  end
               end
            end
            LOW: begin
               if (hp_done) begin
                  tck    <= 1'b1;
                  hp_cnt <= '0;
                  state  <= HIGH;
               end else begin
                  hp_cnt <= hp_cnt + HP_WIDTH'(1);
               end
            end
            HIGH: begin
               // TDO is captured on the last HIGH cycle, i.e. just ahead of the falling edge.
               if (hp_done) begin
                  tck     <= 1'b0;
                  hp_cnt  <= '0;
                  tdo_cap <= tdo_cap | (bit_mask & {DATA_WIDTH{tdo_sync}});
                  if (last_bit) begin
                     state <= RESP;
                  end else begin
                     bit_idx  <= bit_idx + LEN_WIDTH'(1);
                     bit_mask <= bit_mask << 1;
                     tms      <= tms_pend[0];
                     tdi      <= tdi_pend[0];
                     tms_pend <= tms_pend >> 1;
                     tdi_pend <= tdi_pend >> 1;
                     state    <= LOW;
                  end
               end else begin
                  hp_cnt <= hp_cnt + HP_WIDTH'(1);
               end
            end
            RESP: begin
               if (bus.rsp_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
